// File: rtl/led_arbiter.sv
// led_arbiter: round-robin owner of the io_led array with minimum dwell
// time before preemption, and a walking-one heartbeat while idle.
// Ports: clk, reset (sync, active-high), req[NUM_REQ],
//   req_data[NUM_REQ*WIDTH] (requester i at [i*WIDTH +: WIDTH]),
//   grant[NUM_REQ] (one-hot or zero), busy, io_led[WIDTH].
module led_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 24,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic [WIDTH-1:0]           io_led
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam logic [31:0] CNT_MAX = 32'(DWELL_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] WALK_INIT = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  logic [0:0]         state;
  logic [31:0]        cnt;
  logic [WIDTH-1:0]   walk;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      last;

  logic [NUM_REQ-1:0] cand;
  logic [IW-1:0]      scan;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic [WIDTH-1:0]   pick_data;
  logic [WIDTH-1:0]   own_data;
  logic               dwell_done;
  logic [WIDTH-1:0]   walk_nxt;

  assign dwell_done = (cnt == CNT_MAX);

  // Walk rotates only on the heartbeat period boundary.
  assign walk_nxt = dwell_done ?
    {walk[WIDTH-2:0], walk[WIDTH-1]} : walk;

  // The current owner is masked out so a preempt never re-picks it;
  // on release its req is already low, so the mask is harmless.
  always_comb begin
    cand = req;
    if (state == OWN) cand = req & ~(ONE << owner);
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = IW'((int'(last) + k) % NUM_REQ);
      if (!pick_found && cand[scan]) begin
        pick_found = 1'b1;
        pick_idx   = scan;
      end
    end
  end

  assign pick_data = req_data[int'(pick_idx)*WIDTH +: WIDTH];
  assign own_data  = req_data[int'(owner)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      walk   <= WALK_INIT;
      owner  <= '0;
      last   <= LAST_INIT;
      grant  <= '0;
      busy   <= 1'b0;
      io_led <= WALK_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state  <= OWN;
            owner  <= pick_idx;
            last   <= pick_idx;
            grant  <= ONE << pick_idx;
            busy   <= 1'b1;
            cnt    <= '0;
            io_led <= pick_data;
          end else begin
            cnt    <= dwell_done ? '0 : cnt + 32'd1;
            walk   <= walk_nxt;
            io_led <= walk_nxt;
          end
        end
        OWN: begin
          if (!req[owner] || (dwell_done && pick_found)) begin
            if (pick_found) begin
              owner  <= pick_idx;
              last   <= pick_idx;
              grant  <= ONE << pick_idx;
              busy   <= 1'b1;
              cnt    <= '0;
              io_led <= pick_data;
            end else begin
              state  <= IDLE;
              grant  <= '0;
              busy   <= 1'b0;
              cnt    <= '0;
              io_led <= walk;
            end
          end else begin
            io_led <= own_data;
            if (!dwell_done) cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: directed scoreboard bench for led_arbiter with a
// short dwell so heartbeat and preemption are observable.
module tb_led_arbiter;

  localparam int N = 4;
  localparam int W = 24;
  localparam int D = 4;

  localparam logic [W-1:0] D0 = 24'h0F0F0F;
  localparam logic [W-1:0] D1 = 24'h111111;
  localparam logic [W-1:0] D2 = 24'hA5A5A5;
  localparam logic [W-1:0] D3 = 24'h333333;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic           busy;
  logic [W-1:0]   io_led;

  int checks;
  int errors;

  string               tagq[$];
  logic [N+W:0]        expq[$];
  logic [W-1:0]        hb;

  led_arbiter #(
    .NUM_REQ(N),
    .WIDTH(W),
    .DWELL_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .grant(grant),
    .busy(busy),
    .io_led(io_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic exp_next(input string t, input logic [N-1:0] g,
                          input logic [W-1:0] l);
    tagq.push_back(t);
    expq.push_back({g, |g, l});
  endtask

  task automatic tick();
    string        t;
    logic [N+W:0] e;
    logic [N+W:0] o;
    @(posedge clk);
    #1;
    checks++;
    assert ($onehot0(grant)) else begin
      errors++;
      $error("FAIL onehot grant=%b required one-hot or zero", grant);
    end
    if (expq.size() > 0) begin
      t = tagq.pop_front();
      e = expq.pop_front();
      o = {grant, busy, io_led};
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s grant=%b busy=%b led=%h required grant=%b busy=%b led=%h",
               t, grant, busy, io_led, e[N+W:W+1], e[W], e[W-1:0]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    req      = 4'b1111;
    req_data = '0;
    req_data[0*W +: W] = D0;
    req_data[1*W +: W] = D1;
    req_data[2*W +: W] = D2;
    req_data[3*W +: W] = D3;

    for (int i = 0; i < 3; i++) begin
      exp_next("reset_hold", 4'b0000, 24'h000001);
      tick();
    end
    reset = 1'b0;
    exp_next("first_grant_req0", 4'b0001, D0);
    tick();
    req = 4'b0000;
    exp_next("release_to_idle", 4'b0000, 24'h000001);
    tick();

    reset = 1'b1;
    exp_next("reset_again", 4'b0000, 24'h000001);
    tick();
    reset = 1'b0;

    hb = 24'h000001;
    for (int i = 1; i <= 101; i++) begin
      if (i % D == 0) hb = {hb[W-2:0], hb[W-1]};
      exp_next(i == 96 ? "heartbeat_wrap" : "heartbeat", 4'b0000, hb);
      tick();
    end

    req = 4'b0100;
    exp_next("single_grant", 4'b0100, D2);
    tick();
    req_data[2*W +: W] = 24'h123456;
    exp_next("data_follow", 4'b0100, 24'h123456);
    tick();
    for (int i = 0; i < 100; i++) begin
      exp_next("sole_hold", 4'b0100, 24'h123456);
      tick();
    end
    req = 4'b0000;
    exp_next("single_release", 4'b0000, hb);
    tick();
    for (int i = 1; i <= D; i++) begin
      if (i == D) hb = {hb[W-2:0], hb[W-1]};
      exp_next("heartbeat_resume", 4'b0000, hb);
      tick();
    end

    req = 4'b0001;
    exp_next("pre_grant0", 4'b0001, D0);
    tick();
    req = 4'b1011;
    for (int i = 1; i <= 12; i++) begin
      if (i < 4)       exp_next("pre_hold0", 4'b0001, D0);
      else if (i == 4) exp_next("pre_to1", 4'b0010, D1);
      else if (i < 8)  exp_next("pre_hold1", 4'b0010, D1);
      else if (i == 8) exp_next("pre_to3", 4'b1000, D3);
      else if (i < 12) exp_next("pre_hold3", 4'b1000, D3);
      else             exp_next("pre_to0", 4'b0001, D0);
      tick();
    end

    req = 4'b0011;
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) exp_next("hand_hold0", 4'b0001, D0);
      else       exp_next("hand_to1", 4'b0010, D1);
      tick();
    end
    req = 4'b0001;
    exp_next("handoff_1_to_0", 4'b0001, D0);
    tick();

    req = 4'b1000;
    exp_next("handoff_0_to_3", 4'b1000, D3);
    tick();
    exp_next("own3_c1", 4'b1000, D3);
    tick();
    exp_next("own3_c2", 4'b1000, D3);
    tick();
    reset = 1'b1;
    req   = 4'b1001;
    exp_next("mid_reset", 4'b0000, 24'h000001);
    tick();
    reset = 1'b0;
    exp_next("post_reset_req0", 4'b0001, D0);
    tick();

    checks++;
    assert (expq.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain left=%0d required 0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
